// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the data-memory side of the arbiter.
// slave is the arbiter view; master is the view of the requesters plus the memory.
interface dmem_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [DM_ADDRESS-1:0] addr0;
  logic [DM_ADDRESS-1:0] addr1;
  logic [DATA_W-1:0]     wdata0;
  logic [DATA_W-1:0]     wdata1;
  logic [2:0]            f3_0;
  logic [2:0]            f3_1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [DATA_W-1:0]     rdata;
  logic                  stall0;
  logic                  mem_MemRead;
  logic                  mem_MemWrite;
  logic [DM_ADDRESS-1:0] mem_a;
  logic [DATA_W-1:0]     mem_wd;
  logic [2:0]            mem_Funct3;
  logic [DATA_W-1:0]     mem_rd;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, f3_0, f3_1, mem_rd,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, stall0,
    output mem_MemRead, mem_MemWrite, mem_a, mem_wd, mem_Funct3
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, f3_0, f3_1, mem_rd,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, stall0,
    input  mem_MemRead, mem_MemWrite, mem_a, mem_wd, mem_Funct3
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single-port data memory.
// One access per grant: IDLE -> ISSUE (-> RESP for loads) -> IDLE.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input logic            clk,
  input logic            reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              sel;
  logic              sel_next;
  logic              last;
  logic              last_next;
  logic [DATA_W-1:0] rdata_q;

  logic              in_issue;
  logic              in_resp;
  logic              capture;
  logic              issue_en;
  logic              resp_en;
  logic              gnt0_int;
  logic              rvalid0_int;

  logic                  we_sel;
  logic [DM_ADDRESS-1:0] addr_sel;
  logic [DATA_W-1:0]     wdata_sel;
  logic [2:0]            f3_sel;

  assign we_sel    = sel ? bus.we1    : bus.we0;
  assign addr_sel  = sel ? bus.addr1  : bus.addr0;
  assign wdata_sel = sel ? bus.wdata1 : bus.wdata0;
  assign f3_sel    = sel ? bus.f3_1   : bus.f3_0;

  // NOTE: reset is synchronous, so it sits inside the clocked branch; the data
  // register rdata is reset too because its value is architecturally visible.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= 1'b0;
      last    <= 1'b1;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
      last  <= last_next;
      if (capture) rdata_q <= bus.mem_rd;
    end
  end

  // NOTE: every signal assigned here gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    sel_next   = sel;
    last_next  = last;
    in_issue   = 1'b0;
    in_resp    = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          // On a tie the port that did not win last time goes first.
          sel_next   = (bus.req0 & bus.req1) ? ~last : bus.req1;
          last_next  = sel_next;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        in_issue = 1'b1;
        if (we_sel) begin
          state_next = IDLE;
        end else begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        in_resp    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset masks the enables combinationally so an in-flight store never reaches memory.
  assign issue_en = in_issue & ~reset;
  assign resp_en  = in_resp & ~reset;

  assign gnt0_int    = issue_en & ~sel;
  assign rvalid0_int = resp_en & ~sel;

  assign bus.gnt0    = gnt0_int;
  assign bus.gnt1    = issue_en & sel;
  assign bus.rvalid0 = rvalid0_int;
  assign bus.rvalid1 = resp_en & sel;
  assign bus.rdata   = rdata_q;

  assign bus.stall0 = bus.req0 & ~(gnt0_int & bus.we0) & ~rvalid0_int;

  assign bus.mem_MemWrite = issue_en & we_sel;
  assign bus.mem_MemRead  = issue_en & ~we_sel;
  assign bus.mem_a        = issue_en ? addr_sel  : '0;
  assign bus.mem_wd       = issue_en ? wdata_sel : '0;
  assign bus.mem_Funct3   = issue_en ? f3_sel    : 3'b000;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory
// (word-indexed; byte/half accesses use the low lane, loads sign/zero-extend).
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total  = 0;
  int passed = 0;

  logic [31:0] mem_model [0:127];
  logic [31:0] word;

  always @(posedge clk) begin
    if (bus.mem_MemWrite) begin
      case (bus.mem_Funct3[1:0])
        2'b00:   mem_model[bus.mem_a[8:2]][7:0]  <= bus.mem_wd[7:0];
        2'b01:   mem_model[bus.mem_a[8:2]][15:0] <= bus.mem_wd[15:0];
        default: mem_model[bus.mem_a[8:2]]       <= bus.mem_wd;
      endcase
    end
  end

  always_comb begin
    word = mem_model[bus.mem_a[8:2]];
    case (bus.mem_Funct3)
      3'b000:  bus.mem_rd = {{24{word[7]}}, word[7:0]};
      3'b001:  bus.mem_rd = {{16{word[15]}}, word[15:0]};
      3'b100:  bus.mem_rd = {24'h0, word[7:0]};
      3'b101:  bus.mem_rd = {16'h0, word[15:0]};
      default: bus.mem_rd = word;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic r, input logic we, input logic [8:0] a,
                       input logic [31:0] d, input logic [2:0] f3);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.f3_0 = f3;
    end else begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.f3_1 = f3;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) bus.req0 = 1'b0;
    else        bus.req1 = 1'b0;
  endtask

  // Store used to seed memory contents; expects the arbiter in IDLE.
  task automatic do_store(input int p, input logic [8:0] a, input logic [31:0] d,
                          input logic [2:0] f3);
    logic [1:0] g;
    drive(p, 1'b1, 1'b1, a, d, f3);
    tick();
    g = {bus.gnt0, bus.gnt1};
    total++;
    if (g !== ((p == 0) ? 2'b10 : 2'b01))
      $display("FAIL seed_store_gnt port=%0d got=%b exp=%b", p, g, (p == 0) ? 2'b10 : 2'b01);
    else passed++;
    drop(p);
    tick();
  endtask

  task automatic test_reset();
    logic [6:0] v;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    v = {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_MemRead, bus.mem_MemWrite, bus.stall0};
    total++;
    if (v !== 7'b0) $display("FAIL reset_ctrl got=%b exp=0000000", v);
    else passed++;
    total++;
    if (bus.rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=00000000", bus.rdata);
    else passed++;
  endtask

  task automatic test_store();
    logic [4:0] v;
    drive(0, 1'b1, 1'b1, 9'h010, 32'hDEAD_BEEF, 3'b010);
    tick();
    v = {bus.gnt0, bus.gnt1, bus.mem_MemWrite, bus.mem_MemRead, bus.stall0};
    total++;
    if (v !== 5'b10100) $display("FAIL store_issue gnt0,gnt1,we,re,stall0 got=%b exp=10100", v);
    else passed++;
    total++;
    if (bus.mem_a !== 9'h010 || bus.mem_wd !== 32'hDEAD_BEEF || bus.mem_Funct3 !== 3'b010)
      $display("FAIL store_bus got a=%h wd=%h f3=%b exp a=010 wd=deadbeef f3=010",
               bus.mem_a, bus.mem_wd, bus.mem_Funct3);
    else passed++;
    drop(0);
    tick();
    total++;
    if ({bus.gnt0, bus.mem_MemWrite, bus.rvalid0} !== 3'b000)
      $display("FAIL store_done got=%b exp=000", {bus.gnt0, bus.mem_MemWrite, bus.rvalid0});
    else passed++;
  endtask

  task automatic test_load();
    logic [2:0]  f3s  [2] = '{3'b010, 3'b000};
    logic [31:0] exps [2] = '{32'hDEAD_BEEF, 32'hFFFF_FFEF};
    logic [4:0]  v;
    for (int i = 0; i < 2; i++) begin
      drive(0, 1'b1, 1'b0, 9'h010, 32'h0, f3s[i]);
      #1;
      total++;
      if (bus.stall0 !== 1'b1) $display("FAIL load%0d_stall_idle got=%b exp=1", i, bus.stall0);
      else passed++;
      tick();
      v = {bus.gnt0, bus.mem_MemRead, bus.mem_MemWrite, bus.rvalid0, bus.stall0};
      total++;
      if (v !== 5'b11001) $display("FAIL load%0d_issue gnt0,re,we,rv0,stall0 got=%b exp=11001", i, v);
      else passed++;
      tick();
      total++;
      if ({bus.rvalid0, bus.rvalid1, bus.gnt0, bus.stall0} !== 4'b1000)
        $display("FAIL load%0d_resp rv0,rv1,gnt0,stall0 got=%b exp=1000",
                 i, {bus.rvalid0, bus.rvalid1, bus.gnt0, bus.stall0});
      else passed++;
      total++;
      if (bus.rdata !== exps[i]) $display("FAIL load%0d_rdata got=%h exp=%h", i, bus.rdata, exps[i]);
      else passed++;
      drop(0);
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  pat;
    logic [31:0] exp_d;
    do_store(1, 9'h020, 32'h1234_5678, 3'b010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
    drive(1, 1'b1, 1'b0, 9'h020, 32'h0, 3'b010);
    for (int i = 0; i < 8; i++) begin
      pat   = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_d = (i % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678;
      tick();
      total++;
      if ({bus.gnt0, bus.gnt1} !== pat)
        $display("FAIL rr%0d_gnt got=%b exp=%b", i, {bus.gnt0, bus.gnt1}, pat);
      else passed++;
      tick();
      total++;
      if ({bus.rvalid0, bus.rvalid1} !== pat)
        $display("FAIL rr%0d_rvalid got=%b exp=%b", i, {bus.rvalid0, bus.rvalid1}, pat);
      else passed++;
      total++;
      if (bus.rdata !== exp_d) $display("FAIL rr%0d_rdata got=%h exp=%h", i, bus.rdata, exp_d);
      else passed++;
      tick();
    end
    drop(0);
    drop(1);
    tick();
  endtask

  task automatic test_byte_store();
    drive(1, 1'b1, 1'b1, 9'h1F3, 32'h0000_00AA, 3'b000);
    tick();
    total++;
    if ({bus.gnt1, bus.gnt0, bus.mem_MemWrite} !== 3'b101 || bus.mem_a !== 9'h1F3 ||
        bus.mem_Funct3 !== 3'b000)
      $display("FAIL sb_issue got g1,g0,we=%b a=%h f3=%b exp 101 a=1f3 f3=000",
               {bus.gnt1, bus.gnt0, bus.mem_MemWrite}, bus.mem_a, bus.mem_Funct3);
    else passed++;
    drop(1);
    tick();
    drive(0, 1'b1, 1'b0, 9'h1F0, 32'h0, 3'b100);
    #1;
    total++;
    if (bus.stall0 !== 1'b1) $display("FAIL lbu_stall_idle got=%b exp=1", bus.stall0);
    else passed++;
    tick();
    total++;
    if ({bus.gnt0, bus.stall0} !== 2'b11)
      $display("FAIL lbu_issue gnt0,stall0 got=%b exp=11", {bus.gnt0, bus.stall0});
    else passed++;
    tick();
    total++;
    if ({bus.rvalid0, bus.stall0} !== 2'b10)
      $display("FAIL lbu_resp rv0,stall0 got=%b exp=10", {bus.rvalid0, bus.stall0});
    else passed++;
    total++;
    if (bus.rdata !== 32'h0000_00AA) $display("FAIL lbu_rdata got=%h exp=000000aa", bus.rdata);
    else passed++;
    drop(0);
    tick();
  endtask

  task automatic test_reset_abort();
    do_store(0, 9'h040, 32'h0BAD_F00D, 3'b010);
    drive(1, 1'b1, 1'b1, 9'h040, 32'h5555_5555, 3'b010);
    tick();
    total++;
    if (bus.gnt1 !== 1'b1) $display("FAIL abort_pre_gnt1 got=%b exp=1", bus.gnt1);
    else passed++;
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, 9'h040, 32'h0, 3'b010);
    tick();
    reset = 1'b0;
    drive(1, 1'b1, 1'b0, 9'h020, 32'h0, 3'b010);
    #1;
    total++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_MemWrite, bus.mem_MemRead} !== 6'b0)
      $display("FAIL abort_after_reset got=%b exp=000000",
               {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_MemWrite, bus.mem_MemRead});
    else passed++;
    tick();
    total++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10)
      $display("FAIL abort_tie_gnt got=%b exp=10", {bus.gnt0, bus.gnt1});
    else passed++;
    tick();
    total++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata !== 32'h0BAD_F00D)
      $display("FAIL abort_dropped_write got rv0=%b rdata=%h exp rv0=1 rdata=0badf00d",
               bus.rvalid0, bus.rdata);
    else passed++;
    drop(0);
    tick();
    tick();
    total++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01)
      $display("FAIL abort_next_gnt got=%b exp=01", {bus.gnt0, bus.gnt1});
    else passed++;
    drop(1);
    tick();
    total++;
    if (bus.rvalid1 !== 1'b1 || bus.rdata !== 32'h1234_5678)
      $display("FAIL abort_p1_load got rv1=%b rdata=%h exp rv1=1 rdata=12345678",
               bus.rvalid1, bus.rdata);
    else passed++;
    tick();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_MemRead, bus.mem_MemWrite} !== 6'b0 ||
          bus.mem_a !== 9'h0 || bus.mem_wd !== 32'h0 || bus.mem_Funct3 !== 3'b000)
        $display("FAIL idle%0d_ctrl got=%b a=%h wd=%h f3=%b exp all zero", i,
                 {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_MemRead, bus.mem_MemWrite},
                 bus.mem_a, bus.mem_wd, bus.mem_Funct3);
      else passed++;
      total++;
      if (bus.rdata !== 32'h1234_5678) $display("FAIL idle%0d_rdata got=%h exp=12345678", i, bus.rdata);
      else passed++;
    end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
    drive(1, 1'b0, 1'b0, 9'h0, 32'h0, 3'b000);
    test_reset();
    test_store();
    test_load();
    test_round_robin();
    test_byte_store();
    test_reset_abort();
    test_idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
